// File: rtl/effect_pkg.sv
// Shared definitions for the per-sample effect chain: FSM states, slot
// indices, Q1.15 constants and the compressor threshold table.
package effect_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ENV  = 3'd1,
        S_DIV  = 3'd2,
        S_MUL  = 3'd3,
        S_OUT  = 3'd4
    } comp_state_t;

    localparam logic [2:0]  EFF_GATE  = 3'd0;
    localparam logic [2:0]  EFF_COMP  = 3'd1;
    localparam logic [15:0] UNITY     = 16'd32768;
    localparam int          DIV_STEPS = 16;

    // Level 0 disables compression (T = full scale), each step halves T.
    function automatic logic [14:0] comp_threshold(input logic [2:0] level);
        return 15'h7fff >> level;
    endfunction

endpackage

// File: rtl/effect_comp_if.sv
// Sample-stream bundle between the upstream gate and the compressor slot.
interface effect_comp_if;
    logic               i_valid;
    logic               i_enable;
    logic [2:0]         i_level;
    logic signed [15:0] i_data;
    logic signed [15:0] o_data;
    logic               o_valid;
    logic               o_busy;
    logic               o_overrun;
    logic [14:0]        o_env;

    modport master (
        output i_valid, i_enable, i_level, i_data,
        input  o_data, o_valid, o_busy, o_overrun, o_env
    );

    modport slave (
        input  i_valid, i_enable, i_level, i_data,
        output o_data, o_valid, o_busy, o_overrun, o_env
    );
endinterface

// File: rtl/comp_divider.sv
// Restoring divider producing a 16-bit quotient in exactly 16 steps. The first
// step runs on the start edge; caller guarantees dividend[30:16] < divisor.
module comp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [30:0] dividend,
    input  logic [14:0] divisor,
    output logic [15:0] quotient,
    output logic        done
);

    logic [14:0] rem_r;
    logic [15:0] work_r;
    logic [14:0] divisor_r;
    logic [3:0]  cnt_r;
    logic        run_r;
    logic        done_r;

    logic [14:0] step_rem_s;
    logic        step_bit_s;
    logic [14:0] step_div_s;
    logic [15:0] step_s;

    // One restoring step: returns {quotient_bit, new_remainder}.
    function automatic logic [15:0] div_step(input logic [14:0] rem,
                                             input logic        bit_in,
                                             input logic [14:0] dsor);
        logic [15:0] trial;
        logic [15:0] diff;
        trial = {rem, bit_in};
        diff  = trial - {1'b0, dsor};
        if (trial >= {1'b0, dsor}) begin
            return {1'b1, diff[14:0]};
        end else begin
            return {1'b0, trial[14:0]};
        end
    endfunction

    // Operand select: fresh operands on the start edge, stored ones afterwards.
    always_comb begin
        if (run_r) begin
            step_rem_s = rem_r;
            step_bit_s = work_r[15];
            step_div_s = divisor_r;
        end else begin
            step_rem_s = dividend[30:16];
            step_bit_s = dividend[15];
            step_div_s = divisor;
        end
        step_s = div_step(step_rem_s, step_bit_s, step_div_s);
    end

    // Iteration registers; work_r shifts out dividend bits and in quotient bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r     <= 15'd0;
            work_r    <= 16'd0;
            divisor_r <= 15'd0;
            cnt_r     <= 4'd0;
            run_r     <= 1'b0;
            done_r    <= 1'b0;
        end else if (start) begin
            rem_r     <= step_s[14:0];
            work_r    <= {dividend[14:0], step_s[15]};
            divisor_r <= divisor;
            cnt_r     <= 4'd15;
            run_r     <= 1'b1;
            done_r    <= 1'b0;
        end else if (run_r) begin
            rem_r  <= step_s[14:0];
            work_r <= {work_r[14:0], step_s[15]};
            cnt_r  <= cnt_r - 4'd1;
            done_r <= (cnt_r == 4'd1);
            run_r  <= (cnt_r != 4'd1);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = work_r;
    assign done     = done_r;

endmodule

// File: rtl/effect_comp.sv
// Compressor effect slot: peak envelope follower, 2^RATIO_SHIFT:1 gain above a
// level-selected threshold, fixed 19-cycle latency whether enabled or bypassed.
module effect_comp
    import effect_pkg::*;
#(
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 10,
    parameter int RATIO_SHIFT   = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    effect_comp_if.slave bus
);

    comp_state_t        state_r;
    comp_state_t        state_next;

    logic signed [15:0] x_r;
    logic [14:0]        mag_r;
    logic [2:0]         level_r;
    logic               enable_r;
    logic [14:0]        env_r;
    logic               bypass_r;
    logic signed [15:0] y_r;
    logic signed [15:0] data_r;
    logic               valid_r;
    logic               busy_r;
    logic               overrun_r;

    logic               capture_s;
    logic               div_start_s;
    logic               div_done_s;
    logic [15:0]        div_q_s;
    logic [15:0]        neg_s;
    logic [14:0]        mag_in_s;
    logic [14:0]        env_next_s;
    logic [14:0]        thresh_s;
    logic [14:0]        target_s;
    logic               bypass_s;
    logic [15:0]        gain_s;
    logic signed [32:0] prod_s;
    logic signed [17:0] ysh_s;
    logic signed [15:0] y_s;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic and control strobes.
    always_comb begin
        state_next  = state_r;
        capture_s   = 1'b0;
        div_start_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.i_valid) begin
                    state_next = S_ENV;
                    capture_s  = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_ENV: begin
                state_next  = S_DIV;
                div_start_s = 1'b1;
            end
            S_DIV: begin
                if (div_done_s) begin
                    state_next = S_MUL;
                end else begin
                    state_next = S_DIV;
                end
            end
            S_MUL:   state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Magnitude of the incoming sample; -32768 clamps to 32767.
    always_comb begin
        neg_s = 16'd0 - bus.i_data;
        if (bus.i_data == 16'sh8000) begin
            mag_in_s = 15'h7fff;
        end else if (bus.i_data[15]) begin
            mag_in_s = neg_s[14:0];
        end else begin
            mag_in_s = bus.i_data[14:0];
        end
    end

    // Envelope update and target gain operands for the divider.
    always_comb begin
        thresh_s = comp_threshold(level_r);
        if (mag_r > env_r) begin
            env_next_s = env_r + ((mag_r - env_r) >> ATTACK_SHIFT);
        end else if (mag_r < env_r) begin
            env_next_s = env_r - (env_r >> RELEASE_SHIFT);
        end else begin
            env_next_s = env_r;
        end
        bypass_s = (env_next_s <= thresh_s) || (env_next_s == 15'd0);
        target_s = thresh_s + ((env_next_s - thresh_s) >> RATIO_SHIFT);
    end

    // The divider always runs so DIV lasts the same 16 cycles in bypass too.
    comp_divider u_div (
        .clk      (i_clk),
        .rst      (i_rst),
        .start    (div_start_s),
        .dividend ({1'b0, target_s, 15'd0}),
        .divisor  (env_next_s),
        .quotient (div_q_s),
        .done     (div_done_s)
    );

    // Gain multiply with saturation back to 16 bits.
    always_comb begin
        gain_s = bypass_r ? UNITY : div_q_s;
        prod_s = x_r * $signed({1'b0, gain_s});
        ysh_s  = prod_s[32:15];
        if (ysh_s > 18'sd32767) begin
            y_s = 16'sh7fff;
        end else if (ysh_s < -18'sd32768) begin
            y_s = 16'sh8000;
        end else begin
            y_s = ysh_s[15:0];
        end
    end

    // Sample capture, envelope, result and status registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_r       <= 16'sd0;
            mag_r     <= 15'd0;
            level_r   <= 3'd0;
            enable_r  <= 1'b0;
            env_r     <= 15'd0;
            bypass_r  <= 1'b0;
            y_r       <= 16'sd0;
            data_r    <= 16'sd0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            busy_r  <= (state_next != S_IDLE);
            if (bus.i_valid && busy_r) begin
                overrun_r <= 1'b1;
            end
            if (capture_s) begin
                x_r      <= bus.i_data;
                mag_r    <= mag_in_s;
                level_r  <= bus.i_level;
                enable_r <= bus.i_enable;
            end
            if (state_r == S_ENV) begin
                env_r    <= env_next_s;
                bypass_r <= bypass_s;
            end
            if (state_r == S_MUL) begin
                y_r <= y_s;
            end
            if (state_r == S_OUT) begin
                data_r  <= enable_r ? y_r : x_r;
                valid_r <= 1'b1;
            end
        end
    end

    assign bus.o_data    = data_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_busy    = busy_r;
    assign bus.o_overrun = overrun_r;
    assign bus.o_env     = env_r;

endmodule

// File: tb/tb_effect_comp.sv
// Randomized self-checking bench for effect_comp against an arithmetic
// reference model of the compressor rules.
module tb_effect_comp;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   model_env = 0;

    always #5 clk = ~clk;

    effect_comp_if bus ();

    effect_comp dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: envelope, threshold, 4:1 target, floor gain, floor product.
    function automatic int model_out(input int x, input int lvl, input bit en);
        int     mag;
        int     t;
        int     target;
        longint gain;
        longint y;
        mag = (x < 0) ? -x : x;
        if (mag > 32767) mag = 32767;
        if (mag > model_env)      model_env = model_env + (mag - model_env) / 4;
        else if (mag < model_env) model_env = model_env - model_env / 1024;
        t = 32767 >> lvl;
        if (model_env <= t || model_env == 0) begin
            gain = 32768;
        end else begin
            target = t + (model_env - t) / 4;
            gain   = (longint'(target) * 32768) / model_env;
        end
        y = longint'(x) * gain;
        y = y >>> 15;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return en ? int'(y) : x;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_env = 0;
    endtask

    task automatic run_sample(input string tag, input int x, input int lvl,
                              input bit en, output longint got);
        int exp_y;
        int lat;
        exp_y = model_out(x, lvl, en);
        bus.i_valid  = 1'b1;
        bus.i_data   = 16'(x);
        bus.i_level  = 3'(lvl);
        bus.i_enable = en;
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_level  = 3'($urandom_range(0, 7));
        bus.i_enable = 1'($urandom_range(0, 1));
        bus.i_data   = 16'($urandom);
        chk_eq({tag, ".busy"}, bus.o_busy, 1);
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) lat = k;
        end
        chk_eq({tag, ".lat"}, lat, 19);
        chk_eq({tag, ".busy_out"}, bus.o_busy, 0);
        got = bus.o_data;
        chk_eq({tag, ".data"}, bus.o_data, exp_y);
        chk_eq({tag, ".env"}, bus.o_env, model_env);
        @(posedge clk);
        #1;
        chk_eq({tag, ".pulse"}, bus.o_valid, 0);
        chk_eq({tag, ".hold"}, bus.o_data, exp_y);
        repeat (44) @(posedge clk);
        #1;
    endtask

    // Second strobe sampled 'gap' edges after the first must be dropped.
    task automatic overrun_case(input string tag, input int gap);
        int     exp_y;
        int     pulses;
        longint got;
        exp_y = model_out(3000, 6, 1'b1);
        bus.i_valid  = 1'b1;
        bus.i_data   = 16'sd3000;
        bus.i_level  = 3'd6;
        bus.i_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        pulses = 0;
        got = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k == gap) begin
                bus.i_valid = 1'b1;
                bus.i_data  = -16'sd20000;
                bus.i_level = 3'd1;
            end
            @(posedge clk);
            #1;
            bus.i_valid = 1'b0;
            if (bus.o_valid) begin
                pulses++;
                got = bus.o_data;
            end
        end
        chk_eq({tag, ".pulses"}, pulses, 1);
        chk_eq({tag, ".data"}, got, exp_y);
        chk_eq({tag, ".overrun"}, bus.o_overrun, 1);
        chk_eq({tag, ".env"}, bus.o_env, model_env);
        repeat (14) @(posedge clk);
        #1;
    endtask

    initial begin
        longint got;
        int     pulses;
        int     x;

        bus.i_valid  = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_level  = 3'd0;
        bus.i_data   = 16'sd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_env = 0;

        chk_eq("rst.data", bus.o_data, 0);
        chk_eq("rst.valid", bus.o_valid, 0);
        chk_eq("rst.busy", bus.o_busy, 0);
        chk_eq("rst.overrun", bus.o_overrun, 0);
        chk_eq("rst.env", bus.o_env, 0);

        run_sample("first", 1000, 0, 1'b1, got);
        chk_eq("first.const_data", got, 1000);
        chk_eq("first.const_env", bus.o_env, 250);

        for (int i = 0; i < 40; i++) begin
            run_sample("settle", 8000, 7, 1'b1, got);
            if (i >= 30) chk_eq("settle.const_data", got, 2190);
        end
        chk_eq("settle.const_env", bus.o_env, 7997);

        for (int i = 0; i < 4; i++) begin
            run_sample("negfull", -32768, 0, 1'b1, got);
            chk_eq("negfull.const_data", got, -32768);
        end

        do_reset();
        run_sample("bypass", 12345, 7, 1'b0, got);
        chk_eq("bypass.const_data", got, 12345);
        chk_eq("bypass.const_env", bus.o_env, 3086);

        overrun_case("ovr5", 5);
        run_sample("ovr.after", -5000, 3, 1'b1, got);
        chk_eq("ovr.sticky", bus.o_overrun, 1);
        do_reset();
        chk_eq("ovr.rst_clear", bus.o_overrun, 0);
        overrun_case("ovr19", 19);
        do_reset();

        // Reset landing in the middle of the divide phase.
        bus.i_valid  = 1'b1;
        bus.i_data   = 16'sd20000;
        bus.i_level  = 3'd5;
        bus.i_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            rst = (k == 10);
            @(posedge clk);
            #1;
            rst = 1'b0;
            if (bus.o_valid) pulses++;
        end
        model_env = 0;
        chk_eq("midrst.pulses", pulses, 0);
        chk_eq("midrst.data", bus.o_data, 0);
        chk_eq("midrst.env", bus.o_env, 0);
        chk_eq("midrst.busy", bus.o_busy, 0);
        run_sample("midrst.next", 20000, 5, 1'b1, got);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       x = -32768;
                1:       x = 32767;
                2:       x = int'($urandom_range(0, 200)) - 100;
                default: x = int'($urandom_range(0, 65535)) - 32768;
            endcase
            run_sample("rand", x, int'($urandom_range(0, 7)),
                       1'($urandom_range(0, 3) != 0), got);
        end
        chk_eq("final.overrun", bus.o_overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/effect_comp.md
Name: effect_comp

Overview:
- Dynamic-range compressor stage, effect slot 1 (COMP) of the per-sample effect chain.
- Sits directly downstream of the noise gate and consumes its o_data/o_valid pair.
- Tracks a peak envelope, computes a 4:1 gain above a level-selected threshold using a sequential divider, and emits one gain-scaled sample per input sample with fixed latency.
- Runs on the audio bit clock; at least 64 cycles separate input samples.

Parameters:
- ATTACK_SHIFT, 2, envelope rise coefficient (env += diff >>> ATTACK_SHIFT).
- RELEASE_SHIFT, 10, envelope decay coefficient (env -= env >> RELEASE_SHIFT).
- RATIO_SHIFT, 2, compression ratio 2^RATIO_SHIFT:1 above threshold.

Ports:
- i_clk  in  1  audio bit clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  one-cycle strobe: new sample on i_data.
- i_enable  in  1  1 = compress, 0 = bypass with identical latency.
- i_level  in  3  threshold select, sampled with i_valid.
- i_data  in  16  signed input sample.
- o_data  out  16  signed output sample, held between strobes.
- o_valid  out  1  one-cycle strobe, o_data valid.
- o_busy  out  1  high while a sample is in flight.
- o_overrun  out  1  sticky; set when i_valid arrives while busy; cleared only by reset.
- o_env  out  15  current envelope, unsigned debug value.

Behaviour:
- Reset (i_rst high at an edge): state=IDLE, env=0, o_data=0, o_valid=0, o_busy=0, o_overrun=0. Applies mid-operation; the in-flight sample is discarded and no o_valid is produced.
- FSM: IDLE -> ENV (1 cycle) -> DIV (16 cycles) -> MUL (1 cycle) -> OUT (1 cycle) -> IDLE.
- Latency: i_valid sampled high at edge N produces o_valid high for exactly one cycle after edge N+19. o_busy is high from N+1 through N+19.
- IDLE: on i_valid, capture i_data, i_level and i_enable.
  - mag = |x|; -32768 maps to 32767.
- ENV:
  - If mag > env, env += (mag-env) >> ATTACK_SHIFT.
  - If mag < env, env -= env >> RELEASE_SHIFT.
  - If mag = env, env is unchanged.
  - T = 32767 >> level, so level 0 gives T=32767 (no compression).
  - With the updated env: if env <= T or env = 0, gain = 32768 (unsigned Q1.15 unity) and the divider is skipped but its 16 cycles still elapse.
  - Otherwise target = T + ((env-T) >> RATIO_SHIFT).
- DIV: restoring divider, quotient = floor(target*32768 / env). It completes in exactly 16 cycles; quotient < 32768 is guaranteed since target < env.
- MUL: p = x_signed * gain (33-bit signed), y = p >>> 15, saturated to [-32768, 32767].
- OUT:
  - o_data = y when enable=1, else the captured x exactly.
  - o_valid pulses; return to IDLE.
  - The envelope updates regardless of enable.
- i_valid while o_busy: sample dropped, o_overrun set, no effect on the in-flight sample.
- i_valid in the same cycle as OUT is also dropped, since o_busy is still high.
- i_level/i_enable changes mid-sample have no effect until the next capture.

Decomposition:
- Shared package effect_pkg:
  - FSM state enum (S_IDLE, S_ENV, S_DIV, S_MUL, S_OUT).
  - EFF_* slot index constants.
  - Q1.15 UNITY constant (32768).
  - Function comp_threshold(level) -> 15-bit T.
- Sub-module comp_divider: 31-bit dividend / 15-bit divisor, start/done handshake, fixed 16-cycle latency, synchronous active-high reset.

Test Plan:
- Reset, then level=0, enable=1, i_data=1000 -> o_valid exactly 19 cycles later; o_data=1000; o_env=250.
- Level=7 (T=255), enable=1, constant i_data=8000 every 64 cycles for 40 samples -> env settles at 7997; gain=8973; o_data=2190 from sample 30 onward.
- Level=0, i_data=-32768 -> o_data=-32768 (exact unity, no saturation error); o_env grows toward 32767.
- enable=0, level=7, i_data=12345 -> o_data=12345 after 19 cycles; o_env still updates (3086 after one sample from 0).
- Second i_valid 5 cycles after the first -> exactly one o_valid; o_overrun=1 and stays 1 until reset.
- i_rst pulsed 10 cycles after i_valid (in DIV) -> no o_valid; o_data=0, o_env=0, o_busy=0; the next sample completes normally with latency 19.
